cm_sketch_row_update: RTL

Count-min sketch row stage that consumes the per-row hash index produced by the XOR hash pipeline. Each index increments one counter in a W-entry counter RAM through a read-modify-write pipeline with full hazard forwarding. The same port also serves estimate queries. A bulk clear sequencer zeroes the row. One instance per sketch row; the sketch top takes the minimum across rows from `out_count`.

---
 rtl/cm_sketch_pkg.sv | 26 ++
 rtl/cm_sketch_counter_ram.sv | 33 +++
 rtl/cm_sketch_row_update.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cm_sketch_pkg.sv
// Shared types for the count-min sketch row stage: the per-stage pipeline
// op record and the bulk-clear sequencer states.
package cm_sketch_pkg;

    // Default row geometry. The op record below is sized from these, so a
    // different row geometry is set here and the instance parameters follow.
    localparam int unsigned CM_W         = 4096;
    localparam int unsigned CM_HASH_SIZE = $clog2(CM_W);
    localparam int unsigned CM_CNT_SIZE  = 32;

    // Bulk clear sequencer states.
    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_DRAIN = 2'd1,
        CLR_CLEAR = 2'd2
    } clr_state_e;

    // One pipeline slot: an update (is_query = 0) or a query (is_query = 1).
    typedef struct packed {
        logic                    valid;
        logic                    is_query;
        logic [CM_HASH_SIZE-1:0] index;
        logic [CM_CNT_SIZE-1:0]  value;
    } cm_op_t;

endpackage

// File: rtl/cm_sketch_counter_ram.sv
// Simple dual-port counter RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle returns the old data.
module cm_sketch_counter_ram #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    // NOTE: the array has no reset; a reset loop over every entry would stop
    // it mapping onto block RAM. The row is zeroed by the clear sequencer.
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Write port and registered read port share one edge.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make the read sample the pre-write
        // contents, which is exactly the old-data collision behaviour.
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cm_sketch_row_update.sv
// Count-min sketch row stage: read-modify-write increment pipeline with
// S2/S3 forwarding, estimate queries on the same slot, and a bulk clear
// sequencer that drains in-flight ops and then zeroes the whole row.
// Build option: define CM_SKETCH_SATURATE_EN to make increments saturate at
// all-ones instead of wrapping to zero.
module cm_sketch_row_update
    import cm_sketch_pkg::*;
#(
    parameter int unsigned W             = CM_W,
    parameter int unsigned HASH_SIZE     = $clog2(W),
    parameter int unsigned CNT_SIZE      = CM_CNT_SIZE,
    parameter int unsigned DROP_CNT_SIZE = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     upd_valid,
    input  logic [HASH_SIZE-1:0]     upd_index,
    input  logic                     qry_valid,
    input  logic [HASH_SIZE-1:0]     qry_index,
    output logic                     qry_ready,
    input  logic                     clr_start,
    output logic                     clr_busy,
    output logic                     out_valid,
    output logic                     out_is_query,
    output logic [HASH_SIZE-1:0]     out_index,
    output logic [CNT_SIZE-1:0]      out_count,
    output logic [DROP_CNT_SIZE-1:0] drop_cnt
);

    localparam logic [HASH_SIZE-1:0]     LAST_IDX = HASH_SIZE'(W - 1);
    localparam logic [DROP_CNT_SIZE-1:0] DROP_MAX = '1;
`ifdef CM_SKETCH_SATURATE_EN
    localparam logic [CNT_SIZE-1:0]      CNT_MAX  = '1;
`endif

    // Clear sequencer
    clr_state_e           state_q, state_d;
    logic [HASH_SIZE-1:0] clr_idx_q, clr_idx_d;  // drain count, then clear address
    logic                 clr_we;
    logic                 clr_last;

    // Pipeline
    cm_op_t               s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic                 upd_acc, qry_acc, drop_evt;
    logic [CNT_SIZE-1:0]  operand, result;
    logic [DROP_CNT_SIZE-1:0] drop_q, drop_d;

    // RAM ports
    logic                 ram_we;
    logic [HASH_SIZE-1:0] ram_waddr, ram_raddr;
    logic [CNT_SIZE-1:0]  ram_wdata, ram_rdata;

    // Clear sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLR_IDLE;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Clear sequencer next state: IDLE -> DRAIN (2 cycles) -> CLEAR (W cycles).
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            CLR_IDLE: begin
                if (clr_start) begin
                    state_d   = CLR_DRAIN;
                    clr_idx_d = '0;
                end
            end
            CLR_DRAIN: begin
                if (clr_idx_q == HASH_SIZE'(1)) begin
                    state_d   = CLR_CLEAR;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + HASH_SIZE'(1);
                end
            end
            CLR_CLEAR: begin
                clr_idx_d = clr_idx_q + HASH_SIZE'(1);
                if (clr_idx_q == LAST_IDX) begin
                    state_d = CLR_IDLE;
                end
            end
            default: begin
                state_d   = CLR_IDLE;
                clr_idx_d = '0;
            end
        endcase
    end

    // Clear sequencer outputs.
    always_comb begin
        clr_busy = (state_q != CLR_IDLE);
        clr_we   = (state_q == CLR_CLEAR);
        clr_last = clr_we && (clr_idx_q == LAST_IDX);
    end

    // Slot arbitration: updates win, queries only when no update and no clear.
    always_comb begin
        qry_ready = !upd_valid && !clr_busy;
        upd_acc   = upd_valid && !clr_busy;
        qry_acc   = qry_valid && qry_ready;
        drop_evt  = upd_valid && clr_busy;
        ram_raddr = upd_valid ? upd_index : qry_index;

        s1_d          = '0;
        s1_d.valid    = upd_acc || qry_acc;
        s1_d.is_query = !upd_acc;
        s1_d.index    = upd_acc ? upd_index : qry_index;
    end

    // S1 operand select (newest write first) and increment.
    always_comb begin
        if (s2_q.valid && !s2_q.is_query && (s2_q.index == s1_q.index)) begin
            operand = s2_q.value;
        end else if (s3_q.valid && !s3_q.is_query && (s3_q.index == s1_q.index)) begin
            operand = s3_q.value;
        end else begin
            operand = ram_rdata;
        end

        if (s1_q.is_query) begin
            result = operand;
        end else begin
`ifdef CM_SKETCH_SATURATE_EN
            result = (operand == CNT_MAX) ? operand : operand + CNT_SIZE'(1);
`else
            result = operand + CNT_SIZE'(1);
`endif
        end
    end

    // Stage advance; the end of a clear retires any stale forwarding records.
    always_comb begin
        s2_d       = s1_q;
        s2_d.value = result;
        s3_d       = s2_q;
        if (clr_last) begin
            s2_d.valid = 1'b0;
            s3_d.valid = 1'b0;
        end
        drop_d = (drop_evt && (drop_q != DROP_MAX)) ? drop_q + DROP_CNT_SIZE'(1) : drop_q;
    end

    // Pipeline and drop counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            drop_q <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
            drop_q <= drop_d;
        end
    end

    // RAM write port: clear sequencer zeros, otherwise the S2 update commit.
    always_comb begin
        ram_we    = clr_we || (s2_q.valid && !s2_q.is_query);
        ram_waddr = clr_we ? clr_idx_q : s2_q.index;
        ram_wdata = clr_we ? '0 : s2_q.value;
    end

    cm_sketch_counter_ram #(
        .DEPTH (W),
        .AW    (HASH_SIZE),
        .DW    (CNT_SIZE)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign out_valid    = s2_q.valid;
    assign out_is_query = s2_q.is_query;
    assign out_index    = s2_q.index;
    assign out_count    = s2_q.value;
    assign drop_cnt     = drop_q;

endmodule
